dec_addr_looper: RTL and testbench
==================================

# dec_addr_looper

Address sequencer for the LWE decryption datapath, the decrypt-side counterpart of the encryption address looper. On a start pulse it walks every ciphertext k in 0..K-1. For each ciphertext it walks every secret word j in 0..WORDS-1, issuing matched read addresses for the ciphertext vector BRAM (u), the secret BRAM (s) and the ciphertext scalar BRAM (v). It also emits accumulator framing flags so the downstream dot-product/subtract unit can form v − ⟨u, s⟩ per ciphertext.

## Interface
Parameters:
- DEPTH, 100: secret length in coefficients; must be even.
- K, 500: number of ciphertexts decrypted per run.
- WORDS, DEPTH/2: BRAM words per vector (two coefficients per word).
- C_W, $clog2(K*WORDS): width of u address.
- S_W, $clog2(WORDS): width of s address.
- V_W, $clog2(K): width of v address.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-high.
- begin_dec  in  1  start pulse; sampled only in IDLE.
- stall_in  in  1  downstream not ready; the current address set is not consumed.
- c_addr  out  C_W  u word address = k*WORDS + j.
- s_addr  out  S_W  s word address = j.
- v_addr  out  V_W  v address = k.
- first_out  out  1  j == 0 (clear accumulator).
- last_out  out  1  j == WORDS−1 (accumulator complete; consume v[k]).
- addr_valid  out  1  address set on outputs is meaningful.
- busy_out  out  1  high in RUN.
- done_out  out  1  one-cycle pulse after the final set is consumed.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on begin_dec. k, j and c_addr load 0; addr_valid is set.
  - RUN: a set is consumed on a cycle with addr_valid && !stall_in.
  - On consume with j < WORDS−1: j+1, c_addr+1.
  - On consume with j == WORDS−1 and k < K−1: j→0, k+1, c_addr+1.
  - On consume with j == WORDS−1 and k == K−1: go to DONE and clear addr_valid.
  - DONE: done_out=1 for one cycle, then return to IDLE.
- c_addr is kept as a running incrementer. No multiplier is allowed; c_addr must always equal k*WORDS + j.
- While stalled, all outputs hold their values.
- first_out and last_out are registered with the addresses and always match the presented j. When WORDS == 1, both flags are high together.
- begin_dec in RUN or DONE is ignored; there is no restart mid-run.
- Output values in IDLE: addresses keep their last values, flags are 0, addr_valid is 0.

## Timing
- Reset values (asynchronous): state IDLE; c_addr, s_addr, v_addr = 0; first_out, last_out, addr_valid, busy_out, done_out = 0.
- begin_dec high at edge N → at edge N+1 the outputs are set {0,0,0}, with first_out=1, addr_valid=1, busy_out=1.
- Throughput is one set per non-stalled cycle. An unstalled run takes exactly K*WORDS valid cycles, followed by done_out in the next cycle.
- stall_in is combinational into the next-state logic only. No output depends combinationally on any input.
- rst_in asserted mid-RUN: everything returns to reset values immediately. No done_out is produced for the aborted run.
- A begin_dec coincident with rst_in deassertion is ignored until the first clock edge after reset is released.

## Structure
- Shared package lwe_pkg holds:
  - DEPTH, K and WORDS defaults;
  - the derived widths C_W, S_W and V_W;
  - the state enum dec_state_t {IDLE, RUN, DONE}, which the encrypt looper's controller may reuse.
- One sub-module: wrap_counter (enable, async reset, load-zero, MAX parameter, wrap flag output). It is instantiated for j and for k.
- The c_addr incrementer and the FSM live in dec_addr_looper.

## Test plan
Benches use DEPTH=4, K=3 (WORDS=2) unless stated.
- Basic run: reset, pulse begin_dec, stall_in=0 → 6 consecutive sets (c,s,v) = (0,0,0) (1,1,0) (2,0,1) (3,1,1) (4,0,2) (5,1,2). first_out is high on even c and last_out on odd c. done_out is high exactly 1 cycle after the final set, then busy_out=0.
- Stall: hold stall_in=1 for 3 cycles while (2,0,1) is presented → outputs frozen for those cycles. The sequence resumes at (3,1,1), no set is skipped or duplicated, and done_out is delayed by 3 cycles.
- Ignored restart: pulse begin_dec while at (3,1,1) → the sequence is unaffected and exactly 6 sets are issued.
- Async reset mid-run: assert rst_in between clock edges at (4,0,2) → all outputs are 0 and the FSM is in IDLE before the next edge, with no done_out. A following begin_dec restarts from (0,0,0).
- Default parameters (DEPTH=100, K=500) → 25000 valid sets. The last set is c_addr=24999, s_addr=49, v_addr=499. c_addr == v_addr*50 + s_addr holds on every valid cycle.
- WORDS=1 (DEPTH=2, K=2) → sets (0,0,0) and (1,0,1), with first_out and last_out both high on each.

Source files
------------

// File: rtl/lwe_pkg.sv
// Shared LWE parameters, derived address widths and the looper state encoding.
package lwe_pkg;

    localparam int unsigned LWE_DEPTH = 100;
    localparam int unsigned LWE_K     = 500;
    localparam int unsigned LWE_WORDS = LWE_DEPTH / 2;

    // Address width for n locations; never narrower than one bit so that
    // single-entry memories still get a legal port.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LWE_C_W = addr_w(LWE_K * LWE_WORDS);
    localparam int unsigned LWE_S_W = addr_w(LWE_WORDS);
    localparam int unsigned LWE_V_W = addr_w(LWE_K);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } dec_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter 0..MAX with synchronous load-zero and a wrap flag at MAX.
module wrap_counter #(
    parameter int unsigned MAX = 1,
    parameter int unsigned W   = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;

    assign wrap  = (count_q == W'(MAX));
    assign count = count_q;

    // Count register: clear has priority, otherwise step and wrap at MAX.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= wrap ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/dec_addr_looper.sv
// Decrypt address sequencer: walks k over ciphertexts and j over secret words,
// presenting matched u/s/v addresses plus accumulator framing flags.
module dec_addr_looper
    import lwe_pkg::*;
#(
    parameter int unsigned DEPTH = LWE_DEPTH,
    parameter int unsigned K     = LWE_K,
    parameter int unsigned WORDS = DEPTH / 2,
    parameter int unsigned C_W   = addr_w(K * WORDS),
    parameter int unsigned S_W   = addr_w(WORDS),
    parameter int unsigned V_W   = addr_w(K)
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           begin_dec,
    input  logic           stall_in,
    output logic [C_W-1:0] c_addr,
    output logic [S_W-1:0] s_addr,
    output logic [V_W-1:0] v_addr,
    output logic           first_out,
    output logic           last_out,
    output logic           addr_valid,
    output logic           busy_out,
    output logic           done_out
);

    dec_state_t     state_q, state_d;
    logic           start, consume, final_set, advance;
    logic           j_wrap, k_wrap;
    logic [S_W-1:0] j;
    logic [V_W-1:0] k;
    logic [C_W-1:0] c_addr_q;

    assign start     = (state_q == IDLE) && begin_dec;
    assign consume   = (state_q == RUN) && !stall_in;
    assign final_set = j_wrap && k_wrap;
    // The final set is not stepped past, so addresses hold their last values.
    assign advance   = consume && !final_set;

    wrap_counter #(
        .MAX (WORDS - 1),
        .W   (S_W)
    ) u_j_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (start),
        .en     (advance),
        .count  (j),
        .wrap   (j_wrap)
    );

    wrap_counter #(
        .MAX (K - 1),
        .W   (V_W)
    ) u_k_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (start),
        .en     (advance && j_wrap),
        .count  (k),
        .wrap   (k_wrap)
    );

    // Running u address; tracks k*WORDS + j without a multiplier.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            c_addr_q <= '0;
        end else if (start) begin
            c_addr_q <= '0;
        end else if (advance) begin
            c_addr_q <= c_addr_q + C_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; begin_dec only matters in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (begin_dec) state_d = RUN;
            RUN:     if (consume && final_set) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        addr_valid = (state_q == RUN);
        busy_out   = (state_q == RUN);
        done_out   = (state_q == DONE);
        first_out  = addr_valid && (j == '0);
        last_out   = addr_valid && j_wrap;
    end

    assign c_addr = c_addr_q;
    assign s_addr = j;
    assign v_addr = k;

endmodule

// File: tb/tb_dec_addr_looper.sv
// Directed bench for dec_addr_looper with a scoreboard of expected address sets.
module tb_dec_addr_looper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic beg0 = 1'b0, stall0 = 1'b0, beg1 = 1'b0, beg2 = 1'b0;

    // DEPTH=4, K=3
    logic [2:0]  c0;
    logic        s0;
    logic [1:0]  v0;
    logic        f0, l0, av0, b0, d0;
    // DEPTH=2, K=2 (WORDS=1)
    logic        c1, s1, v1, f1, l1, av1, b1, d1;
    // default parameters
    logic [14:0] c2;
    logic [5:0]  s2;
    logic [8:0]  v2;
    logic        f2, l2, av2, b2, d2;

    dec_addr_looper #(.DEPTH(4), .K(3)) u0 (
        .clk_in(clk), .rst_in(rst), .begin_dec(beg0), .stall_in(stall0),
        .c_addr(c0), .s_addr(s0), .v_addr(v0), .first_out(f0), .last_out(l0),
        .addr_valid(av0), .busy_out(b0), .done_out(d0)
    );

    dec_addr_looper #(.DEPTH(2), .K(2)) u1 (
        .clk_in(clk), .rst_in(rst), .begin_dec(beg1), .stall_in(1'b0),
        .c_addr(c1), .s_addr(s1), .v_addr(v1), .first_out(f1), .last_out(l1),
        .addr_valid(av1), .busy_out(b1), .done_out(d1)
    );

    dec_addr_looper u2 (
        .clk_in(clk), .rst_in(rst), .begin_dec(beg2), .stall_in(1'b0),
        .c_addr(c2), .s_addr(s2), .v_addr(v2), .first_out(f2), .last_out(l2),
        .addr_valid(av2), .busy_out(b2), .done_out(d2)
    );

    typedef struct {
        int c;
        int s;
        int v;
        bit f;
        bit l;
    } set_t;

    set_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int nk, input int nw);
        set_t e;
        for (int kk = 0; kk < nk; kk++) begin
            for (int jj = 0; jj < nw; jj++) begin
                e.c = kk * nw + jj;
                e.s = jj;
                e.v = kk;
                e.f = (jj == 0);
                e.l = (jj == nw - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c"}, 32'(c0), 0);
        chk({tag, "_s"}, 32'(s0), 0);
        chk({tag, "_v"}, 32'(v0), 0);
        chk({tag, "_first"}, 32'(f0), 0);
        chk({tag, "_last"}, 32'(l0), 0);
        chk({tag, "_valid"}, 32'(av0), 0);
        chk({tag, "_busy"}, 32'(b0), 0);
        chk({tag, "_done"}, 32'(d0), 0);
    endtask

    // One run on u0; negative arguments disable stall / restart / abort.
    task automatic run0(input string tag, input int stall_c, input int stall_n,
                        input int restart_c, input int abort_c, input int exp_done);
        set_t e;
        int   n = 0, cyc = 0, done_cyc = -1, dones = 0;
        bit   stalled = 0, aborted = 0;
        beg0 = 1'b1;
        tick();
        beg0 = 1'b0;
        push_run(3, 2);
        while (cyc < 40 && done_cyc < 0) begin
            if (d0) begin
                done_cyc = cyc;
                chk({tag, "_busy_at_done"}, 32'(b0), 0);
            end else if (av0) begin
                if (sb.size() == 0) begin
                    chk({tag, "_extra_set"}, 1, 0);
                    break;
                end
                e = sb[0];
                if (e.c == abort_c) begin
                    #2 rst = 1'b1;
                    #1 chk_all_zero({tag, "_abort"});
                    tick();
                    rst = 1'b0;
                    repeat (5) begin
                        tick();
                        if (d0) dones++;
                    end
                    chk({tag, "_abort_no_done"}, dones, 0);
                    aborted = 1;
                    break;
                end
                if (e.c == stall_c && !stalled) begin
                    stalled = 1;
                    stall0  = 1'b1;
                    repeat (stall_n) begin
                        tick();
                        cyc++;
                        chk({tag, "_hold_c"}, 32'(c0), e.c);
                        chk({tag, "_hold_s"}, 32'(s0), e.s);
                        chk({tag, "_hold_v"}, 32'(v0), e.v);
                        chk({tag, "_hold_valid"}, 32'(av0), 1);
                    end
                    stall0 = 1'b0;
                end
                chk({tag, "_c"}, 32'(c0), e.c);
                chk({tag, "_s"}, 32'(s0), e.s);
                chk({tag, "_v"}, 32'(v0), e.v);
                chk({tag, "_first"}, 32'(f0), 32'(e.f));
                chk({tag, "_last"}, 32'(l0), 32'(e.l));
                chk({tag, "_busy"}, 32'(b0), 1);
                void'(sb.pop_front());
                n++;
                if (e.c == restart_c) beg0 = 1'b1;
            end
            tick();
            beg0 = 1'b0;
            cyc++;
        end
        if (aborted) begin
            sb.delete();
        end else begin
            chk({tag, "_n_sets"}, n, 6);
            chk({tag, "_done_cycle"}, done_cyc, exp_done);
            chk({tag, "_sb_empty"}, sb.size(), 0);
            chk({tag, "_post_busy"}, 32'(b0), 0);
            chk({tag, "_post_valid"}, 32'(av0), 0);
            chk({tag, "_post_first"}, 32'(f0), 0);
            tick();
            chk({tag, "_post_done"}, 32'(d0), 0);
            chk({tag, "_idle_busy"}, 32'(b0), 0);
        end
    endtask

    initial begin
        set_t e;
        int   mk, mj, n, errs, lc, ls, lv;

        // Reset state.
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk_all_zero("idle");

        run0("basic", -1, 0, -1, -1, 6);
        run0("stall", 2, 3, -1, -1, 9);
        run0("restart", -1, 0, 3, -1, 6);
        run0("abort", -1, 0, -1, 4, 0);
        run0("after_abort", -1, 0, -1, -1, 6);

        // WORDS == 1: both flags on every set.
        beg1 = 1'b1;
        tick();
        beg1 = 1'b0;
        push_run(2, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("w1_valid", 32'(av1), 1);
            chk("w1_c", 32'(c1), e.c);
            chk("w1_s", 32'(s1), e.s);
            chk("w1_v", 32'(v1), e.v);
            chk("w1_first", 32'(f1), 32'(e.f));
            chk("w1_last", 32'(l1), 32'(e.l));
            tick();
        end
        chk("w1_done", 32'(d1), 1);
        chk("w1_valid_end", 32'(av1), 0);

        // Default parameters: full 25000-set walk.
        beg2 = 1'b1;
        tick();
        beg2 = 1'b0;
        mk = 0; mj = 0; n = 0; errs = 0; lc = -1; ls = -1; lv = -1;
        while (av2 && n < 30000) begin
            if (c2 !== 15'(mk * 50 + mj) || s2 !== 6'(mj) || v2 !== 9'(mk)) errs++;
            if (32'(c2) !== 32'(v2) * 50 + 32'(s2)) errs++;
            if (f2 !== (mj == 0) || l2 !== (mj == 49)) errs++;
            lc = int'(c2); ls = int'(s2); lv = int'(v2);
            n++;
            if (mj == 49) begin
                mj = 0;
                mk++;
            end else begin
                mj++;
            end
            tick();
        end
        chk("def_errors", errs, 0);
        chk("def_n_sets", n, 25000);
        chk("def_last_c", lc, 24999);
        chk("def_last_s", ls, 49);
        chk("def_last_v", lv, 499);
        chk("def_done", 32'(d2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
